// File: rtl/ssds_mux_driver_pkg.sv
// ssds_mux_driver_pkg
// Shared definitions for the seven-segment display scan path: FSM state
// encoding, segment bit order, digit count and the pin polarity helper.
package ssds_mux_driver_pkg;

   // Scan FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } ssd_state_e;

   // Segment bit order within a digit pattern: a = bit0 .. g = bit6
   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;
   localparam int unsigned SEG_W = 7;

   localparam int unsigned NUM_DIGITS = 4;

   // Convert a "1 = lit" pattern into physical pin levels.
   function automatic logic [SEG_W-1:0] seg_to_pins(input logic [SEG_W-1:0] lit,
                                                    input logic active_low);
      return active_low ? ~lit : lit;
   endfunction

endpackage

// File: rtl/ssds_scan_timer.sv
// ssds_scan_timer
// Owns the per-window cycle counter and the digit index of the scan.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear_i           force cycle counter and digit index to 0
//   run_i             advance the counter this cycle (ignored while clear_i)
//   digit_idx_o       digit currently being scanned
//   blank_done_o      last cycle of the blanking part of the window
//   window_done_o     last cycle of the digit window
//   frame_wrap_o      last cycle of the last digit window of a frame
module ssds_scan_timer
   import ssds_mux_driver_pkg::*;
#(
   parameter int unsigned DIGIT_CYCLES = 50000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic       run_i,
   output logic [1:0] digit_idx_o,
   output logic       blank_done_o,
   output logic       window_done_o,
   output logic       frame_wrap_o
);

   localparam int unsigned CNT_W = $clog2(DIGIT_CYCLES);
   localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [1:0]       DIGIT_LAST  = 2'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [1:0]       digit_idx_q, digit_idx_d;

   assign blank_done_o  = (cycle_cnt_q == BLANK_LAST);
   assign window_done_o = (cycle_cnt_q == WINDOW_LAST);
   assign frame_wrap_o  = window_done_o && (digit_idx_q == DIGIT_LAST);
   assign digit_idx_o   = digit_idx_q;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      digit_idx_d = digit_idx_q;
      if (clear_i) begin
         cycle_cnt_d = '0;
         digit_idx_d = '0;
      end else if (run_i) begin
         if (window_done_o) begin
            cycle_cnt_d = '0;
            digit_idx_d = digit_idx_q + 2'd1;   // wraps 3 -> 0
         end else begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         digit_idx_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         digit_idx_q <= digit_idx_d;
      end
   end

endmodule

// File: rtl/ssds_mux_driver.sv
// ssds_mux_driver
// Time-multiplexes four snapshotted 7-segment digits onto a shared-segment
// 4-digit display, with a blanking gap at the start of every digit window.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ctrl_en               display enable
//   ctrl_digit_0..3       per-digit segment pattern, bit0=a..bit6=g, 1 = lit
//   ctrl_dots             bit i = dot of digit i, 1 = lit
//   ssd_segments, ssd_dot physical segment/dot pins (SEG_ACTIVE_LOW polarity)
//   ssd_anodes            physical digit enables (AN_ACTIVE_LOW polarity)
//   frame_start           one-cycle pulse when a new snapshot is taken
module ssds_mux_driver
   import ssds_mux_driver_pkg::*;
#(
   parameter int unsigned DIGIT_CYCLES   = 50000,
   parameter int unsigned BLANK_CYCLES   = 500,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctrl_en,
   input  logic [SEG_W-1:0] ctrl_digit_0,
   input  logic [SEG_W-1:0] ctrl_digit_1,
   input  logic [SEG_W-1:0] ctrl_digit_2,
   input  logic [SEG_W-1:0] ctrl_digit_3,
   input  logic [3:0]       ctrl_dots,
   output logic [SEG_W-1:0] ssd_segments,
   output logic             ssd_dot,
   output logic [3:0]       ssd_anodes,
   output logic             frame_start
);

   localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
   localparam logic             DOT_OFF = SEG_ACTIVE_LOW;
   localparam logic [3:0]       AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

   ssd_state_e state_q, state_d;

   logic [NUM_DIGITS-1:0][SEG_W-1:0] snap_dig_q, snap_dig_d;
   logic [NUM_DIGITS-1:0]            snap_dot_q, snap_dot_d;

   logic [SEG_W-1:0] seg_q, seg_d;
   logic             dot_q, dot_d;
   logic [3:0]       an_q, an_d;
   logic             fs_q, fs_d;

   logic [1:0] digit_idx;
   logic       blank_done, window_done, frame_wrap;
   logic       tmr_clear, tmr_run;
   logic       snap_load;
   logic [3:0] an_lit;

   // Counters run only while scanning; any exit to IDLE clears them.
   assign tmr_clear = (state_q == ST_IDLE) || !ctrl_en;
   assign tmr_run   = !tmr_clear;

   ssds_scan_timer #(
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_scan_timer (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (tmr_clear),
      .run_i         (tmr_run),
      .digit_idx_o   (digit_idx),
      .blank_done_o  (blank_done),
      .window_done_o (window_done),
      .frame_wrap_o  (frame_wrap)
   );

   always_comb begin
      state_d   = state_q;
      snap_load = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ctrl_en) begin
               state_d   = ST_BLANK;
               snap_load = 1'b1;
            end
         end
         ST_BLANK: begin
            if (!ctrl_en)        state_d = ST_IDLE;
            else if (blank_done) state_d = ST_SHOW;
         end
         ST_SHOW: begin
            if (!ctrl_en) begin
               state_d = ST_IDLE;
            end else if (window_done) begin
               state_d   = ST_BLANK;
               snap_load = frame_wrap;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      snap_dig_d = snap_dig_q;
      snap_dot_d = snap_dot_q;
      if (snap_load) begin
         snap_dig_d = {ctrl_digit_3, ctrl_digit_2, ctrl_digit_1, ctrl_digit_0};
         snap_dot_d = ctrl_dots;
      end
   end

   // Output stage is computed from the next state so the registered pins
   // reflect the state entered on the same edge. digit_idx only changes on
   // the edge that leaves SHOW, so its current value is valid for state_d.
   always_comb begin
      an_lit            = '0;
      an_lit[digit_idx] = 1'b1;
      seg_d = SEG_OFF;
      dot_d = DOT_OFF;
      an_d  = AN_OFF;
      fs_d  = snap_load;
      if (state_d == ST_SHOW) begin
         seg_d = seg_to_pins(snap_dig_d[digit_idx], SEG_ACTIVE_LOW);
         dot_d = SEG_ACTIVE_LOW ? ~snap_dot_d[digit_idx] : snap_dot_d[digit_idx];
         an_d  = AN_ACTIVE_LOW ? ~an_lit : an_lit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         snap_dig_q <= '0;
         snap_dot_q <= '0;
         seg_q      <= SEG_OFF;
         dot_q      <= DOT_OFF;
         an_q       <= AN_OFF;
         fs_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_dig_q <= snap_dig_d;
         snap_dot_q <= snap_dot_d;
         seg_q      <= seg_d;
         dot_q      <= dot_d;
         an_q       <= an_d;
         fs_q       <= fs_d;
      end
   end

   assign ssd_segments = seg_q;
   assign ssd_dot      = dot_q;
   assign ssd_anodes   = an_q;
   assign frame_start  = fs_q;

endmodule

// File: tb/tb_ssds_mux_driver.sv
// tb_ssds_mux_driver
// Randomized and directed stimulus against a time-based reference model:
// while enabled, position t in the frame fixes digit = t / DIGIT and
// lit = (t % DIGIT) >= BLANK.
module tb_ssds_mux_driver;

   localparam int DC = 8;
   localparam int BC = 2;
   localparam int FRAME = 4 * DC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ctrl_en = 1'b0;
   logic [6:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
   logic [3:0] dots = '0;
   logic [6:0] ssd_segments;
   logic       ssd_dot;
   logic [3:0] ssd_anodes;
   logic       frame_start;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit         m_run = 0;
   int         m_t   = 0;
   logic [6:0] m_dig [4];
   logic [3:0] m_dots = '0;
   bit         m_fs  = 0;

   // gap tracking
   int off_run   = 0;
   bit lit_valid = 0;

   always #5 clk = ~clk;

   ssds_mux_driver #(
      .DIGIT_CYCLES   (DC),
      .BLANK_CYCLES   (BC),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ctrl_en      (ctrl_en),
      .ctrl_digit_0 (d0),
      .ctrl_digit_1 (d1),
      .ctrl_digit_2 (d2),
      .ctrl_digit_3 (d3),
      .ctrl_dots    (dots),
      .ssd_segments (ssd_segments),
      .ssd_dot      (ssd_dot),
      .ssd_anodes   (ssd_anodes),
      .frame_start  (frame_start)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic take_snapshot();
      m_dig[0] = d0; m_dig[1] = d1; m_dig[2] = d2; m_dig[3] = d3;
      m_dots   = dots;
   endtask

   // One clock: update model with the inputs seen at the edge, then compare.
   task automatic cycle();
      int         dig;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dot;
      @(posedge clk);
      m_fs = 0;
      if (rst) begin
         m_run = 0; m_t = 0;
         for (int i = 0; i < 4; i++) m_dig[i] = '0;
         m_dots = '0;
         lit_valid = 0;
      end else if (!m_run) begin
         if (ctrl_en) begin
            m_run = 1; m_t = 0; m_fs = 1;
            take_snapshot();
         end
      end else if (!ctrl_en) begin
         m_run = 0; m_t = 0;
         lit_valid = 0;
      end else begin
         m_t = (m_t + 1) % FRAME;
         if (m_t == 0) begin
            m_fs = 1;
            take_snapshot();
         end
      end
      e_an = 4'hF; e_seg = 7'h7F; e_dot = 1'b1;
      if (m_run && (m_t % DC) >= BC) begin
         dig   = m_t / DC;
         e_an  = ~(4'b0001 << dig);
         e_seg = ~m_dig[dig];
         e_dot = ~m_dots[dig];
      end
      @(negedge clk);
      check("anodes", ssd_anodes, e_an);
      check("segments", ssd_segments, e_seg);
      check("dot", ssd_dot, e_dot);
      check("frame_start", frame_start, m_fs);
      check("one_anode", ($countones(~ssd_anodes) <= 1), 1);
      if (ssd_anodes == 4'hF) begin
         off_run++;
      end else begin
         if (lit_valid && off_run > 0) check("blank_gap", off_run, BC);
         off_run   = 0;
         lit_valid = m_run;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic run_until_t(input int target);
      for (int i = 0; i < 2 * FRAME && m_t != target; i++) cycle();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_dig[i] = '0;
      // 1: reset, then idle with enable low
      rst = 1; ctrl_en = 0;
      run(2);
      rst = 0;
      run(20);

      // 2: enable with the test pattern, two full frames
      d0 = 7'h3F; d1 = 7'h06; d2 = 7'h5B; d3 = 7'h4F; dots = 4'b0101;
      ctrl_en = 1;
      run(2 * FRAME);

      // 3: change digit 0 while digit 2 is shown
      run_until_t(2 * DC + 4);
      d0 = 7'h7F;
      run(FRAME + 8);

      // 4: drop enable during digit 2, then re-enable
      run_until_t(2 * DC + 3);
      ctrl_en = 0;
      run(6);
      ctrl_en = 1;
      run(12);

      // 5: reset during digit 3 with enable held high
      run_until_t(3 * DC + 4);
      rst = 1;
      run(1);
      rst = 0;
      run(FRAME + 4);

      // 6: random traffic
      for (int i = 0; i < 1000; i++) begin
         if (ctrl_en) ctrl_en = ($urandom_range(0, 99) != 0);
         else         ctrl_en = ($urandom_range(0, 4) == 0);
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 4))
               0: d0 = 7'($urandom);
               1: d1 = 7'($urandom);
               2: d2 = 7'($urandom);
               3: d3 = 7'($urandom);
               default: dots = 4'($urandom);
            endcase
         end
         cycle();
      end
      rst = 0;
      run(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
